// File: rtl/mem_scan_ctrl_if.sv
// Memory-port and dump-stream bundle for mem_scan_ctrl.
// The master side is the controller; the slave side is the paired memory and the stream consumer.
interface mem_scan_ctrl_if #(
    parameter int unsigned WID_MEM = 15
);
    logic [31:0]        mem_raddr;
    logic [31:0]        mem_waddr;
    logic [WID_MEM-1:0] mem_din;
    logic               mem_we;
    logic [WID_MEM-1:0] mem_dout;
    logic [WID_MEM-1:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;

    modport master (
        output mem_raddr, mem_waddr, mem_din, mem_we, m_data, m_valid, m_last,
        input  mem_dout, m_ready
    );

    modport slave (
        input  mem_raddr, mem_waddr, mem_din, mem_we, m_data, m_valid, m_last,
        output mem_dout, m_ready
    );
endinterface

// File: rtl/mem_scan_ctrl.sv
// Memory scan controller: fills a memory with seed+addr, or dumps it through a
// 2-entry skid buffer onto a valid/ready stream while accumulating an XOR checksum.
module mem_scan_ctrl #(
    parameter int unsigned WID_MEM   = 15,
    parameter int unsigned DEPTH_MEM = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [WID_MEM-1:0] seed,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [WID_MEM-1:0] checksum,
    mem_scan_ctrl_if.master    bus
);
    localparam int unsigned   AW        = $clog2(DEPTH_MEM);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

    typedef enum logic [2:0] {IDLE, FILL, DUMP, DRAIN, FIN} state_t;

    state_t             state_q;
    logic [AW-1:0]      raddr_q;
    logic [AW-1:0]      waddr_q;
    logic [WID_MEM-1:0] din_q;
    logic [WID_MEM-1:0] chk_q;
    logic               we_q;
    logic               done_q;
    logic               pend_q;
    logic               last_pend_q;
    logic [WID_MEM-1:0] buf_q [2];
    logic [1:0]         blast_q;
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         cnt_q;
    logic [1:0]         cnt_d;

    logic          start_dump;
    logic [AW-1:0] rd_addr;
    logic          rd_last;
    logic          valid;
    logic          pop;
    logic [2:0]    occ;
    logic          issue;

    // The start cycle itself presents address 0 so the first beat is valid two cycles later.
    // A read may issue only if, counting the word in flight, the buffer cannot overflow.
    always_comb begin
        start_dump = (state_q == IDLE) && start && !mode;
        rd_addr    = start_dump ? '0 : raddr_q;
        rd_last    = (rd_addr == LAST_ADDR);
        valid      = (cnt_q != 2'd0);
        pop        = valid && bus.m_ready;
        occ        = 3'(cnt_q) + 3'(pend_q);
        issue      = start_dump ||
                     ((state_q == DUMP) && !abort && (occ <= 3'd1 + 3'(pop)));
        cnt_d      = cnt_q + 2'(pend_q) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            raddr_q     <= '0;
            waddr_q     <= '0;
            din_q       <= '0;
            chk_q       <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            last_pend_q <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            blast_q     <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pend_q      <= issue;
            last_pend_q <= issue && rd_last;
            if (issue) begin
                raddr_q <= rd_last ? rd_addr : rd_addr + AW'(1);
            end
            if (pend_q) begin
                buf_q[wr_ptr_q]   <= bus.mem_dout;
                blast_q[wr_ptr_q] <= last_pend_q;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                chk_q    <= chk_q ^ buf_q[rd_ptr_q];
            end
            cnt_q <= cnt_d;

            // Abort branches come last so their flush overrides the buffer updates above.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        chk_q <= '0;
                        if (mode) begin
                            state_q <= FILL;
                            we_q    <= 1'b1;
                            waddr_q <= '0;
                            din_q   <= seed;
                        end else begin
                            state_q <= DUMP;
                        end
                    end
                end
                FILL: begin
                    if (abort) begin
                        state_q <= IDLE;
                        we_q    <= 1'b0;
                    end else if (waddr_q == LAST_ADDR) begin
                        state_q <= FIN;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        waddr_q <= waddr_q + AW'(1);
                        din_q   <= din_q + WID_MEM'(1);
                    end
                end
                DUMP, DRAIN: begin
                    if (abort) begin
                        state_q  <= IDLE;
                        pend_q   <= 1'b0;
                        cnt_q    <= '0;
                        wr_ptr_q <= 1'b0;
                        rd_ptr_q <= 1'b0;
                    end else if (state_q == DUMP) begin
                        if (issue && rd_last) begin
                            state_q <= DRAIN;
                        end
                    end else if (pop && blast_q[rd_ptr_q]) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_raddr = 32'(rd_addr);
    assign bus.mem_waddr = 32'(waddr_q);
    assign bus.mem_din   = din_q;
    assign bus.mem_we    = we_q;
    assign bus.m_data    = buf_q[rd_ptr_q];
    assign bus.m_valid   = valid;
    assign bus.m_last    = valid && blast_q[rd_ptr_q];
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign checksum      = chk_q;
endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Directed bench for mem_scan_ctrl with a 16-word registered-read memory model.
module tb_mem_scan_ctrl;
    localparam int unsigned WID   = 15;
    localparam int unsigned DEPTH = 16;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           mode  = 1'b0;
    logic           abort = 1'b0;
    logic [WID-1:0] seed  = '0;
    logic           busy;
    logic           done;
    logic [WID-1:0] checksum;

    mem_scan_ctrl_if #(.WID_MEM(WID)) bus ();

    mem_scan_ctrl #(.WID_MEM(WID), .DEPTH_MEM(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .seed     (seed),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [WID-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_waddr[3:0]] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_raddr[3:0]];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    logic [WID-1:0] exp_cur [DEPTH];

    always @(negedge clk) if (done) n_done++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".raddr"}, bus.mem_raddr, 32'd0);
        check_eq({tag, ".waddr"}, bus.mem_waddr, 32'd0);
        check_eq({tag, ".din"},   32'(bus.mem_din), 32'd0);
        check_eq({tag, ".we"},    32'(bus.mem_we), 32'd0);
        check_eq({tag, ".valid"}, 32'(bus.m_valid), 32'd0);
        check_eq({tag, ".last"},  32'(bus.m_last), 32'd0);
        check_eq({tag, ".data"},  32'(bus.m_data), 32'd0);
        check_eq({tag, ".busy"},  32'(busy), 32'd0);
        check_eq({tag, ".done"},  32'(done), 32'd0);
        check_eq({tag, ".chk"},   32'(checksum), 32'd0);
    endtask

    // Fill with seed s; a stray DUMP start is pulsed mid-fill and again in FIN.
    task automatic run_fill(input string tag, input logic [WID-1:0] s, input int rst_at);
        start = 1'b1; mode = 1'b1; seed = s;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            check_eq({tag, ".we"},    32'(bus.mem_we), 32'd1);
            check_eq({tag, ".waddr"}, bus.mem_waddr, 32'(i));
            check_eq({tag, ".din"},   32'(bus.mem_din), 32'(exp_cur[i]));
            if (i == rst_at) begin
                reset = 1'b0;
                tick();
                check_zero({tag, ".rst"});
                reset = 1'b1;
                tick();
                return;
            end
            if (i == 5) begin start = 1'b1; mode = 1'b0; end
            tick();
            start = 1'b0;
        end
        check_eq({tag, ".done"}, 32'(done), 32'd1);
        check_eq({tag, ".we_fin"}, 32'(bus.mem_we), 32'd0);
        check_eq({tag, ".busy_fin"}, 32'(busy), 32'd1);
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        check_eq({tag, ".idle"}, 32'(busy), 32'd0);
        check_eq({tag, ".done_off"}, 32'(done), 32'd0);
        check_eq({tag, ".waddr_hold"}, bus.mem_waddr, 32'(DEPTH - 1));
    endtask

    task automatic run_dump(input string tag, input bit rnd, input int abort_at);
        int idx, c;
        bit fin, pv, pr, pl;
        logic [WID-1:0] pd, chk;
        idx = 0; c = 0; fin = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; chk = '0;
        for (int i = 0; i < int'(DEPTH); i++) chk ^= exp_cur[i];
        bus.m_ready = 1'b1; start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        while (c < 200) begin
            if (done) begin fin = 1'b1; break; end
            if (c == 0) begin
                check_eq({tag, ".valid_c1"}, 32'(bus.m_valid), 32'd0);
                check_eq({tag, ".raddr_c1"}, bus.mem_raddr, 32'd1);
            end
            if (c == 1) check_eq({tag, ".valid_c2"}, 32'(bus.m_valid), 32'd1);
            if (pv && !pr) begin
                check_eq({tag, ".stall_valid"}, 32'(bus.m_valid), 32'd1);
                check_eq({tag, ".stall_data"}, 32'(bus.m_data), 32'(pd));
                check_eq({tag, ".stall_last"}, 32'(bus.m_last), 32'(pl));
            end
            bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pv = bus.m_valid; pr = bus.m_ready; pd = bus.m_data; pl = bus.m_last;
            if (pv && pr) begin
                check_eq({tag, ".data"}, 32'(pd), 32'(exp_cur[4'(idx)]));
                check_eq({tag, ".last"}, 32'(pl), 32'(idx == int'(DEPTH) - 1));
                if (idx == abort_at) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    check_eq({tag, ".abort_valid"}, 32'(bus.m_valid), 32'd0);
                    check_eq({tag, ".abort_busy"}, 32'(busy), 32'd0);
                    check_eq({tag, ".abort_done"}, 32'(done), 32'd0);
                    return;
                end
                idx++;
            end
            tick();
            c++;
        end
        check_eq({tag, ".timeout"}, 32'(fin), 32'd1);
        check_eq({tag, ".beats"}, 32'(idx), 32'(DEPTH));
        if (!rnd) check_eq({tag, ".done_cycle"}, 32'(c), 32'd17);
        check_eq({tag, ".chk"}, 32'(checksum), 32'(chk));
        tick();
        check_eq({tag, ".idle"}, 32'(busy), 32'd0);
        check_eq({tag, ".chk_hold"}, 32'(checksum), 32'(chk));
        check_eq({tag, ".raddr_hold"}, bus.mem_raddr, 32'(DEPTH - 1));
    endtask

    initial begin
        bus.m_ready = 1'b0;
        repeat (3) tick();
        check_zero("por");
        reset = 1'b1;
        tick();

        // seed 0x7FFE wraps: 7FFE, 7FFF, 0000..000D
        for (int i = 0; i < int'(DEPTH); i++)
            exp_cur[i] = (i < 2) ? WID'(15'h7FFE + i) : WID'(i - 2);
        run_fill("fill1", 15'h7FFE, -1);
        for (int i = 0; i < int'(DEPTH); i++)
            check_eq("fill1.mem", 32'(mem[i]), 32'(exp_cur[i]));
        check_eq("fill1.xor", 32'((15'h7FFE ^ 15'h7FFF) ^ 15'h0001), 32'(exp_cur[0] ^ exp_cur[1] ^ exp_cur[3]));
        run_dump("dump1", 1'b0, -1);

        for (int i = 0; i < int'(DEPTH); i++) exp_cur[i] = WID'(i + 3);
        run_fill("fill2", 15'h0003, -1);
        run_dump("dump_abort", 1'b0, 5);
        run_dump("dump_rnd", 1'b1, -1);
        check_eq("dump_rnd.chk_val", 32'(checksum), 32'h10);

        for (int i = 0; i < int'(DEPTH); i++) exp_cur[i] = WID'(15'h55 + i);
        run_fill("fill3", 15'h0055, 8);
        for (int i = 0; i < int'(DEPTH); i++)
            check_eq("fill3.mem", 32'(mem[i]), (i <= 8) ? 32'(15'h55 + i) : 32'(i + 3));
        for (int i = 0; i < int'(DEPTH); i++)
            exp_cur[i] = (i <= 8) ? WID'(15'h55 + i) : WID'(i + 3);
        run_dump("dump4", 1'b1, -1);

        check_eq("done_count", 32'(n_done), 32'd5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/mem_scan_ctrl.md
MEM_SCAN_CTRL -- requirements
Module: mem_scan_ctrl

Interface
REQ-001 SHALL have parameter WID_MEM, default 15, memory word width in bits.
REQ-002 SHALL have parameter DEPTH_MEM, default 1024, number of memory words; power of two, >= 4.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port mode, input, 1, 0=DUMP, 1=FILL; sampled with start.
REQ-007 SHALL have port seed, input, WID_MEM, fill base value; sampled with start.
REQ-008 SHALL have port abort, input, 1, terminate the active operation.
REQ-009 SHALL have port mem_raddr, output, 32, read address to the memory.
REQ-010 SHALL have port mem_waddr, output, 32, write address to the memory.
REQ-011 SHALL have port mem_din, output, WID_MEM, write data to the memory.
REQ-012 SHALL have port mem_we, output, 1, write enable; the paired memory gates its write with it.
REQ-013 SHALL have port mem_dout, input, WID_MEM, memory read data; 1-cycle registered latency from mem_raddr.
REQ-014 SHALL have port m_data, output, WID_MEM, dump stream data.
REQ-015 SHALL have port m_valid, output, 1, dump stream valid.
REQ-016 SHALL have port m_ready, input, 1, dump stream ready from the consumer.
REQ-017 SHALL have port m_last, output, 1, marks the beat for address DEPTH_MEM-1.
REQ-018 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-019 SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-020 SHALL have port checksum, output, WID_MEM, XOR of all dumped words; held stable from done until next start.

Function
REQ-021 SHALL implement states IDLE, FILL, DUMP, DRAIN, FIN.
REQ-022 SHALL move IDLE->FILL (mode=1) or IDLE->DUMP (mode=0) on start; start outside IDLE ignored.
REQ-023 FILL SHALL assert mem_we for exactly DEPTH_MEM consecutive cycles, mem_waddr 0..DEPTH_MEM-1, mem_din = (seed + addr) mod 2^WID_MEM.
REQ-024 SHALL move FILL->FIN in the cycle after the write to DEPTH_MEM-1; mem_we SHALL be 0 in every non-FILL state.
REQ-025 DUMP SHALL issue reads 0..DEPTH_MEM-1 in order, at most one per cycle, only when the output buffer has room for the returning word.
REQ-026 SHALL buffer returning words in a 2-entry skid buffer so that with m_ready held high one beat transfers per cycle, with no gaps after the first.
REQ-027 The first m_valid SHALL occur 2 cycles after the start cycle.
REQ-028 m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0; a beat transfers only when both are high.
REQ-029 No word SHALL be dropped or duplicated under any m_ready pattern; beat order equals address order.
REQ-030 SHALL move DUMP->DRAIN after the last read issues, and DRAIN->FIN on the transfer of the m_last beat.
REQ-031 checksum SHALL clear to 0 on start and XOR each transferred beat.
REQ-032 FIN SHALL last one cycle with done=1, then return to IDLE; start in FIN ignored.
REQ-033 abort in FILL/DUMP/DRAIN SHALL force IDLE next cycle: mem_we=0, m_valid=0, buffer flushed, no done, checksum undefined.
REQ-034 abort in IDLE or FIN SHALL have no effect.
REQ-035 mem_raddr/mem_waddr SHALL hold their last value when not advancing; upper bits above log2(DEPTH_MEM) SHALL be 0.

Reset
REQ-036 reset=0 at a clock edge SHALL force IDLE and clear the skid buffer and address counters.
REQ-037 While in reset, all outputs SHALL be 0, including mem_raddr, mem_waddr, mem_din, mem_we, m_valid, m_last, busy, done, checksum.
REQ-038 Reset mid-operation SHALL behave as abort, except that checksum is cleared; the first start after release SHALL behave as after power-up.

Verification
REQ-039 DEPTH_MEM=16, FILL, seed=0x7FFE -> 16 writes, data 0x7FFE,0x7FFF,0x0000..0x000D, done at cycle 17 after start.
REQ-040 After REQ-039, DUMP with m_ready=1 -> 16 back-to-back beats matching the fill data, m_last on beat 15, checksum = XOR of the 16 words.
REQ-041 DUMP with m_ready toggling 1,0,0,1 pseudo-randomly -> identical data sequence, no drop or duplicate, data stable while stalled.
REQ-042 abort at beat 5 of DUMP -> m_valid=0 next cycle, busy=0, no done; a subsequent DUMP restarts at address 0.
REQ-043 reset=0 during FILL at address 8 -> all outputs 0 next cycle, mem_we=0; addresses 9..15 unwritten.
REQ-044 start pulsed during busy and during FIN -> ignored; exactly one done per accepted start.
